// File: rtl/lfm_pkg.sv
// Shared constants and helpers for the LFM sample-stream blocks.
// Samples carry I in the upper half-word and Q in the lower half-word.
package lfm_pkg;

    localparam int LFM_DATA_W    = 32;
    localparam int LFM_I_MSB     = 31;
    localparam int LFM_Q_MSB     = 15;
    localparam int LFM_FRAME_LEN = 1024;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; the head entry is visible on
// rd_data whenever the FIFO is not empty, and reads as zero when it is empty.
module sync_fifo_fwft
    import lfm_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [clog2(DEPTH):0] level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_wr, do_rd;

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign level = level_q;
    // Gate the head so an empty FIFO never exposes unwritten storage.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        level_d  = level_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/lfm_stream_framer.sv
// Buffers the free-running LFM sample stream into a ready/valid stream with a
// per-chirp tlast; samples arriving while the buffer is full are counted and lost.
module lfm_stream_framer
    import lfm_pkg::*;
#(
    parameter int DATA_W    = LFM_DATA_W,
    parameter int DEPTH     = 64,
    parameter int FRAME_LEN = LFM_FRAME_LEN,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  lfm_valid,
    input  logic [DATA_W-1:0]     lfm_data,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_W-1:0]     m_tdata,
    output logic                  m_tlast,
    output logic [clog2(DEPTH):0] level,
    output logic                  overflow,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int             IW       = clog2(FRAME_LEN);
    localparam logic [IW-1:0]  IDX_LAST = IW'(FRAME_LEN - 1);

    logic [IW-1:0]    idx_q, idx_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             accept, wr, drop, rd;
    logic             fifo_empty, fifo_full;
    logic [DATA_W:0]  fifo_rd_data;

    always_comb begin
        accept = enable && lfm_valid;
        // Full is judged on the pre-edge level, so a same-cycle pop does not
        // make room for the incoming sample.
        wr     = accept && !fifo_full;
        drop   = accept && fifo_full;
        rd     = m_tvalid && m_tready;

        // Index advances on every accepted strobe, stored or not, so chirp
        // alignment survives drops.
        idx_d = idx_q;
        if (!enable)
            idx_d = '0;
        else if (lfm_valid)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

        overflow_d = overflow_q || drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr),
        .wr_data ({idx_q == IDX_LAST, lfm_data}),
        .rd_en   (rd),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (level)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_rd_data[DATA_W-1:0];
    assign m_tlast  = fifo_rd_data[DATA_W];
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_lfm_stream_framer.sv
// Directed bench for lfm_stream_framer with a queue scoreboard; a second
// instance with a 4-bit drop counter shares the stimulus to check saturation.
module tb_lfm_stream_framer;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int FL = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          reset, enable, lfm_valid, m_tready;
    logic [DW-1:0] lfm_data;

    logic          m_tvalid, m_tlast, overflow;
    logic [DW-1:0] m_tdata;
    logic [LW-1:0] level;
    logic [15:0]   drop_cnt;

    logic          s_tvalid, s_tlast, s_overflow;
    logic [DW-1:0] s_tdata;
    logic [LW-1:0] s_level;
    logic [3:0]    s_drop_cnt;

    always #5 clk = ~clk;

    lfm_stream_framer #(.DATA_W(DW), .DEPTH(DP), .FRAME_LEN(FL), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .lfm_valid(lfm_valid), .lfm_data(lfm_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    lfm_stream_framer #(.DATA_W(DW), .DEPTH(DP), .FRAME_LEN(FL), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .lfm_valid(lfm_valid), .lfm_data(lfm_data),
        .m_tvalid(s_tvalid), .m_tready(m_tready), .m_tdata(s_tdata), .m_tlast(s_tlast),
        .level(s_level), .overflow(s_overflow), .drop_cnt(s_drop_cnt)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: queue of {last, data}, frame index, drop bookkeeping.
    logic [DW:0] sb[$];
    int          m_idx  = 0;
    int          m_drop = 0;
    bit          m_ovf  = 0;

    always @(posedge clk) begin
        bit accept, full, do_rd;
        if (reset) begin
            sb.delete();
            m_idx  = 0;
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            accept = enable && lfm_valid;
            full   = (sb.size() == DP);
            do_rd  = (sb.size() != 0) && m_tready;
            if (accept && full) begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
            if (do_rd) void'(sb.pop_front());
            if (accept && !full) sb.push_back({(m_idx == FL - 1), lfm_data});
            if (!enable) m_idx = 0;
            else if (lfm_valid) m_idx = (m_idx + 1) % FL;
        end
    end

    // Output monitor: compares the DUT head against the scoreboard every cycle.
    bit          chk_on = 0;
    bit          stall_prev = 0;
    logic [DW:0] held;
    int          hs_cnt = 0;
    int          tl_cnt = 0;
    logic [DW-1:0] last_tl_data = '0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("level", level, sb.size());
            chk("tvalid", m_tvalid, sb.size() != 0);
            if (sb.size() != 0) begin
                chk("tdata", m_tdata, sb[0][DW-1:0]);
                chk("tlast", m_tlast, sb[0][DW]);
            end
            chk("drop_cnt", drop_cnt, m_drop);
            chk("sat_drop_cnt", s_drop_cnt, (m_drop > 15) ? 15 : m_drop);
            chk("overflow", overflow, m_ovf);
            if (stall_prev && !reset) chk("stall_hold", {m_tlast, m_tdata}, held);
            stall_prev = m_tvalid && !m_tready && !reset;
            held       = {m_tlast, m_tdata};
            if (m_tvalid && m_tready && !reset) begin
                hs_cnt++;
                if (m_tlast) begin
                    tl_cnt++;
                    last_tl_data = m_tdata;
                end
            end
        end
    end

    int n = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v);
        lfm_valid = v;
        lfm_data  = 32'h0001_0000 + n;
        if (v) n++;
    endtask

    task automatic drain();
        lfm_valid = 1'b0;
        m_tready  = 1'b1;
        for (int i = 0; i < 60 && level != 0; i++) tick();
        chk("drain_level", level, 0);
    endtask

    initial begin
        logic [DW-1:0] exp_last;
        reset = 1'b1; enable = 1'b0; lfm_valid = 1'b0; m_tready = 1'b0; lfm_data = '0;
        repeat (4) tick();
        chk("rst_level", level, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk_on = 1;
        reset = 1'b0;

        // 1: streaming at full rate
        enable = 1'b1; m_tready = 1'b1;
        hs_cnt = 0; tl_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            drive(1);
            tick();
            chk("t1_tvalid", m_tvalid, 1);
            chk("t1_level_le1", level <= 1, 1);
        end
        drain();
        chk("t1_count", hs_cnt, 24);
        chk("t1_tlasts", tl_cnt, 3);
        chk("t1_no_drop", drop_cnt, 0);

        // 2: backpressure fill with overflow
        m_tready = 1'b0;
        n = 0; hs_cnt = 0; tl_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1);
            tick();
        end
        lfm_valid = 1'b0;
        chk("t2_level_full", level, 16);
        chk("t2_overflow", overflow, 1);
        chk("t2_drop_cnt", drop_cnt, 4);
        drain();
        chk("t2_count", hs_cnt, 16);
        chk("t2_tlasts", tl_cnt, 2);
        chk("t2_last_data", last_tl_data, 32'h0001_000f);

        // 3: stalls with continuous input
        hs_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                m_tready = (k == 0 || k == 3);
                drive(1);
                tick();
            end
        end
        drain();
        chk("t3_count", hs_cnt, 16);
        chk("t3_no_drop", drop_cnt, 4);

        // 4: full with simultaneous read and write
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1);
            tick();
        end
        chk("t4_level_full", level, 16);
        m_tready = 1'b1;
        drive(1);
        tick();
        chk("t4_level", level, 15);
        chk("t4_drop_cnt", drop_cnt, 5);
        drain();

        // 5a: enable low clears frame position
        for (int i = 0; i < 3; i++) begin
            drive(1);
            tick();
        end
        enable = 1'b0;
        drive(1);
        tick();
        drive(1);
        tick();
        chk("t5_dis_drop_cnt", drop_cnt, 5);
        enable = 1'b1;
        lfm_valid = 1'b0;
        tick();
        tl_cnt = 0; last_tl_data = '0;
        exp_last = 32'h0001_0000 + n + 7;
        for (int i = 0; i < 8; i++) begin
            drive(1);
            tick();
        end
        drain();
        chk("t5_tlasts", tl_cnt, 1);
        chk("t5_last_data", last_tl_data, exp_last);

        // 5b: reset with data buffered
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1);
            tick();
        end
        chk("t5_level5", level, 5);
        lfm_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_level", level, 0);
        chk("t5_rst_tvalid", m_tvalid, 0);
        chk("t5_rst_drop_cnt", drop_cnt, 0);
        chk("t5_rst_overflow", overflow, 0);

        // 6: drop counter saturation on the narrow instance
        for (int i = 0; i < 36; i++) begin
            drive(1);
            tick();
        end
        lfm_valid = 1'b0;
        chk("t6_drop_cnt", drop_cnt, 20);
        chk("t6_sat_drop_cnt", s_drop_cnt, 15);
        chk("t6_sat_overflow", s_overflow, 1);
        drain();

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lfm_stream_framer.md
Name: lfm_stream_framer

Overview:
- Downstream stage of the LFM foldback generator. Consumes its free-running 32-bit sample stream (lfm_valid/lfm_data) and buffers it in a FIFO.
- Re-emits the samples on a ready/valid stream with a per-chirp end marker, so DMA or packetiser blocks can apply backpressure.
- The upstream block cannot be stalled. The framer absorbs bursts, and it detects and counts lost samples.

Parameters:
- DATA_W, 32, sample width; bits [31:16] are I and [15:0] are Q, passed through untouched.
- DEPTH, 64, FIFO entries; must be a power of two, at least 4.
- FRAME_LEN, 1024, samples per chirp; m_tlast marks sample FRAME_LEN-1 of each chirp; must be at least 2.
- CNT_W, 16, width of drop_cnt.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = accept samples; 0 = ignore input and clear frame position.
- lfm_valid  in  1  sample strobe from the upstream generator.
- lfm_data  in  DATA_W  sample from the upstream generator.
- m_tvalid  out  1  output sample valid.
- m_tready  in  1  consumer ready.
- m_tdata  out  DATA_W  output sample.
- m_tlast  out  1  last sample of a chirp.
- level  out  clog2(DEPTH)+1  entries currently held, 0..DEPTH.
- overflow  out  1  sticky; set when any sample has been dropped.
- drop_cnt  out  CNT_W  saturating count of dropped samples.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - level=0, m_tvalid=0, m_tdata=0, m_tlast=0, overflow=0, drop_cnt=0, frame index=0.
  - FIFO contents are don't-care.
- Reset asserted mid-operation discards all buffered data on that edge.
- Frame index idx (0..FRAME_LEN-1):
  - Advances on every cycle with enable && lfm_valid, whether or not the sample is stored.
  - Wraps from FRAME_LEN-1 to 0.
  - Forced to 0 on any cycle with enable=0.
  - Consequence: chirp alignment survives drops.
- Write:
  - wr = enable && lfm_valid && (level != DEPTH).
  - Stores {last, data}, where last = (idx == FRAME_LEN-1).
  - full is evaluated on the pre-edge level. A write while full is dropped even if a read happens in the same cycle. This is deliberate and conservative.
- Drop:
  - enable && lfm_valid && level==DEPTH.
  - Sets overflow, and increments drop_cnt, saturating at 2^CNT_W-1.
  - A dropped tlast sample means that frame has no m_tlast. Downstream uses overflow to detect this.
- Read:
  - rd = m_tvalid && m_tready.
  - Pops the oldest entry.
  - m_tdata/m_tlast must hold stable while m_tvalid && !m_tready.
- Level update: level_next = level + wr - rd. A simultaneous wr and rd leaves level unchanged.
- Output:
  - First-word-fall-through: m_tvalid = (level != 0), driven from registered state.
  - Latency: a sample written into an empty FIFO on edge N is presented after edge N, i.e. m_tvalid=1 in cycle N+1.
  - With m_tready held at 1 and a sample every cycle, throughput is 1/cycle and level holds at 1.
- Pointers: wrap modulo DEPTH, natural binary wrap.
- enable=0:
  - Input is ignored; the FIFO continues draining.
  - No drops are counted.
  - overflow and drop_cnt are held.
- m_tready is don't-care while m_tvalid=0. m_tvalid never depends combinationally on m_tready.
- No X on any output after reset.

Decomposition:
- Shared package lfm_pkg:
  - Constants LFM_DATA_W=32, LFM_I_MSB=31, LFM_Q_MSB=15, LFM_FRAME_LEN default.
  - Function clog2.
- Sub-module sync_fifo_fwft:
  - Parameters WIDTH, DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data, empty, full, level.
  - Instantiated with WIDTH=DATA_W+1.
- The top level holds the frame counter, drop logic and counters.

Test Plan (DEPTH=16, FRAME_LEN=8, CNT_W=16, samples 0x00010000+n):
1. Streaming: reset high 4 cycles, then enable=1, m_tready=1, lfm_valid every cycle for 24 samples.
   - Outputs appear in order, 1 cycle after input; level stays at most 1.
   - m_tlast=1 exactly on samples n=7, 15, 23; no drops.
2. Backpressure fill: m_tready=0, 20 valid samples.
   - level reaches 16; samples 16..19 dropped; overflow=1, drop_cnt=4.
   - Then m_tready=1: exactly samples 0..15 emerge; m_tlast on 7 and 15; level returns to 0.
3. Stall stability: m_tready toggles 1,0,0,1 with continuous input.
   - m_tdata/m_tlast unchanged across stall cycles; no sample lost or duplicated.
4. Full plus simultaneous read/write: FIFO at 16 entries, then m_tready=1 and lfm_valid=1 in the same cycle.
   - Read occurs; write dropped (drop_cnt+1); level goes to 15.
5. enable/reset mid-stream:
   - enable=0 after 3 samples, then re-enabled: the next accepted sample carries idx 0, so m_tlast falls on its 8th sample.
   - reset pulse with 5 entries buffered: the next cycle gives level=0, m_tvalid=0, drop_cnt=0, overflow=0.
6. Saturation (CNT_W=4 build): 20 drops → drop_cnt stays at 15; overflow=1.
